// File: rtl/operand_fetch.sv
// operand_fetch: operand bypass, load-use hazard detection and registered execute-stage operands
module operand_fetch #(
  parameter int CTRL_W = 16,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic              in_use_rs1,
  input  logic              in_use_rs2,
  input  logic [4:0]        in_rd,
  input  logic [31:0]       in_imm,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic [4:0]        rf_addr_a,
  output logic [4:0]        rf_addr_b,
  input  logic [31:0]       rf_data_a,
  input  logic [31:0]       rf_data_b,
  input  logic              ex_valid,
  input  logic              ex_is_load,
  input  logic [4:0]        ex_rd,
  input  logic [31:0]       ex_data,
  input  logic              mem_valid,
  input  logic [4:0]        mem_rd,
  input  logic [31:0]       mem_data,
  input  logic              wb_we,
  input  logic [4:0]        wb_addr,
  input  logic [31:0]       wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_op_a,
  output logic [31:0]       out_op_b,
  output logic [31:0]       out_imm,
  output logic [4:0]        out_rd,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_count
);
  logic [31:0] op_a, op_b;
  logic hazard, accept;
  assign rf_addr_a = in_rs1;
  assign rf_addr_b = in_rs2;
  always_comb begin
    op_a = in_rs1 == 5'd0 ? 32'd0 :
           (ex_valid && !ex_is_load && ex_rd == in_rs1) ? ex_data :
           (mem_valid && mem_rd == in_rs1) ? mem_data :
           (wb_we && wb_addr == in_rs1) ? wb_data : rf_data_a;
    op_b = in_rs2 == 5'd0 ? 32'd0 :
           (ex_valid && !ex_is_load && ex_rd == in_rs2) ? ex_data :
           (mem_valid && mem_rd == in_rs2) ? mem_data :
           (wb_we && wb_addr == in_rs2) ? wb_data : rf_data_b;
    hazard = in_valid && ex_valid && ex_is_load && ex_rd != 5'd0 &&
             ((in_use_rs1 && in_rs1 == ex_rd) || (in_use_rs2 && in_rs2 == ex_rd));
    in_ready = (!out_valid || out_ready) && !hazard;
    accept = in_valid && in_ready && !flush;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_op_a <= '0;
      out_op_b <= '0;
      out_imm <= '0;
      out_rd <= '0;
      out_ctrl <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_op_a <= op_a;
      out_op_b <= op_b;
      out_imm <= in_imm;
      out_rd <= in_rd;
      out_ctrl <= in_ctrl;
    end else if (out_ready && out_valid) begin
      out_valid <= 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_count <= '0;
    else if (hazard && !flush && stall_count != '1) stall_count <= stall_count + CNT_W'(1);
  end
endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Decode-to-execute pipeline stage of the llama core.
- Drives the register file's two combinational read addresses and resolves operand bypass from the EX, MEM and WB stages.
- Detects load-use hazards and registers the resolved operands for the execute stage behind a valid/ready handshake.
- Includes a saturating stall counter for performance debug.

Parameters:
- CTRL_W, 16, width of the opaque decoded-control bundle passed through unchanged.
- CNT_W, 16, width of the load-use stall counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  discard the instruction being accepted and the output register content
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts the instruction this cycle
- in_rs1, in_rs2  in  5 each  source register indices
- in_use_rs1, in_use_rs2  in  1 each  the instruction reads that source
- in_rd  in  5  destination index
- in_imm  in  32  immediate
- in_ctrl  in  CTRL_W  decoded control bundle
- rf_addr_a, rf_addr_b  out  5 each  register-file read addresses; equal to in_rs1 and in_rs2, combinational
- rf_data_a, rf_data_b  in  32 each  register-file read data, combinational
- ex_valid, ex_is_load  in  1 each  EX holds a register-writing instruction; the instruction is a load
- ex_rd  in  5  EX destination
- ex_data  in  32  EX result; meaningless when ex_is_load=1
- mem_valid  in  1  MEM holds a register-writing instruction
- mem_rd  in  5  MEM destination
- mem_data  in  32  MEM result
- wb_we  in  1  register-file write enable this cycle
- wb_addr  in  5  register-file write address
- wb_data  in  32  register-file write data
- out_valid  out  1  registered operands valid
- out_ready  in  1  execute stage consumes
- out_op_a, out_op_b  out  32 each  resolved source operands
- out_imm  out  32  registered immediate
- out_rd  out  5  registered destination
- out_ctrl  out  CTRL_W  registered control bundle
- stall_count  out  CNT_W  saturating count of load-use stall cycles

Behaviour:
- Reset values: out_valid=0, out_op_a=0, out_op_b=0, out_imm=0, out_rd=0, out_ctrl=0, stall_count=0.
- Operand resolution for each source s (combinational, per operand):
  - s==0 gives 0.
  - Otherwise priority: ex_valid&&!ex_is_load&&ex_rd==s gives ex_data.
  - Then mem_valid&&mem_rd==s gives mem_data.
  - Then wb_we&&wb_addr==s gives wb_data. The register file writes at the clock edge, so this bypass is mandatory.
  - Otherwise the value is rf_data.
  - A destination of 0 never forwards.
- hazard = in_valid && ex_valid && ex_is_load && ex_rd!=0 && ((in_use_rs1&&in_rs1==ex_rd) || (in_use_rs2&&in_rs2==ex_rd)).
  - An unused source never causes a hazard.
- Handshake:
  - in_ready = (!out_valid || out_ready) && !hazard.
  - accept = in_valid && in_ready && !flush.
- Output register update at the clock edge, in priority order:
  1. flush: out_valid<=0.
  2. accept: load all out_* fields from the resolved values; out_valid<=1.
  3. out_ready && out_valid: out_valid<=0. This covers a bubble inserted on hazard.
  4. Otherwise hold all out_* fields.
- Latency: operands are presented one cycle after acceptance.
- While out_valid=1 and out_ready=0, the output is stable and no new instruction is accepted.
- flush has priority over accept and over hazard. in_ready may still read 1 during flush, but the instruction is dropped and upstream must discard it as well.
- stall_count increments on each cycle with hazard=1 and !flush, and saturates at all-ones.
- Reset asserted mid-operation clears all state immediately; there is no partial transfer.
- The stage never stalls for a non-load EX producer.

Test Plan:
- x1 register-file value 0x11, rs1=1, rs2=0, no bypass active -> out_op_a=0x11, out_op_b=0, out_valid=1 one cycle after accept.
- rs1=5 with ex_valid, ex_rd=5, ex_data=0xAAAA, and simultaneously mem_rd=5, mem_data=0xBBBB, wb_addr=5, wb_data=0xCCCC -> out_op_a=0xAAAA. Drop ex_valid -> 0xBBBB. Drop mem_valid -> 0xCCCC.
- ex_is_load=1, ex_rd=3, in_rs2=3, in_use_rs2=1 -> in_ready=0 and stall_count=1 after one cycle. Next cycle, with ex cleared and mem_rd=3, mem_data=0x77, the instruction is accepted with out_op_b=0x77.
- Same load case with in_use_rs2=0 -> no stall; also ex_rd=0 with in_rs1=0 -> out_op_a=0 and no stall.
- out_ready=0 for 3 cycles with in_valid=1 -> out_* held and in_ready=0. Raise out_ready -> the next instruction is accepted on that edge.
- flush asserted together with a valid accept -> out_valid=0 the next cycle. rst asserted mid-stall -> out_valid=0 and stall_count=0 immediately, without waiting for a clock edge.
